// File: rtl/cache_arbiter.sv
// cache_arbiter
// Shares the single physical-memory port between the instruction cache and
// the data cache. Each request is captured into the memory command registers
// when it is granted, so memory sees a stable command for the whole transfer.
// Only the completion strobe is routed back to one cache. Both caches always
// see the read data.

module cache_arbiter #(
   parameter int LINE_WIDTH = 128,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,

   input  logic                  i_pmem_read,
   input  logic [ADDR_WIDTH-1:0] i_pmem_address,
   output logic                  i_pmem_resp,
   output logic [LINE_WIDTH-1:0] i_pmem_rdata,

   input  logic                  d_pmem_read,
   input  logic                  d_pmem_write,
   input  logic [ADDR_WIDTH-1:0] d_pmem_address,
   input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
   output logic                  d_pmem_resp,
   output logic [LINE_WIDTH-1:0] d_pmem_rdata,

   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp
);

   typedef enum logic [1:0] {
      IDLE,
      SERVE_I,
      SERVE_D
   } state_t;

   localparam logic GRANT_I = 1'b0;
   localparam logic GRANT_D = 1'b1;

   state_t state;
   logic   last_grant;
   logic   i_valid;
   logic   d_valid;
   logic   pick_d;
   logic   pick_i;

   // The D port wins when it is the only requester. It also wins a tie if
   // the I port was the last one served.
   always_comb begin
      i_valid = i_pmem_read;
      d_valid = d_pmem_read | d_pmem_write;
      pick_d  = d_valid & (~i_valid | (last_grant == GRANT_I));
      pick_i  = i_valid & ~pick_d;
   end

   // The grant FSM captures the winning request into the memory command
   // registers. It holds them until memory completes, and then it always
   // passes through IDLE before it accepts another request.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         last_grant   <= GRANT_I;
         pmem_read    <= 1'b0;
         pmem_write   <= 1'b0;
         pmem_address <= '0;
         pmem_wdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_d) begin
                  state        <= SERVE_D;
                  last_grant   <= GRANT_D;
                  pmem_address <= {d_pmem_address[ADDR_WIDTH-1:4], 4'b0000};
                  pmem_wdata   <= d_pmem_wdata;
                  pmem_write   <= d_pmem_write;
                  pmem_read    <= d_pmem_read & ~d_pmem_write;
               end else if (pick_i) begin
                  state        <= SERVE_I;
                  last_grant   <= GRANT_I;
                  pmem_address <= {i_pmem_address[ADDR_WIDTH-1:4], 4'b0000};
                  pmem_write   <= 1'b0;
                  pmem_read    <= 1'b1;
               end
            end
            SERVE_I, SERVE_D: begin
               if (pmem_resp) begin
                  state      <= IDLE;
                  pmem_read  <= 1'b0;
                  pmem_write <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               pmem_read  <= 1'b0;
               pmem_write <= 1'b0;
            end
         endcase
      end
   end

   // The completion strobe goes only to the cache that is being served, in
   // the same cycle memory raises it. Both caches receive the read data.
   always_comb begin
      i_pmem_resp  = (state == SERVE_I) & pmem_resp;
      d_pmem_resp  = (state == SERVE_D) & pmem_resp;
      i_pmem_rdata = pmem_rdata;
      d_pmem_rdata = pmem_rdata;
   end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter
// Scoreboard bench for cache_arbiter. The stimulus pushes each memory
// transaction it expects, in the order it expects them. A monitor pops an
// entry each time a new memory command appears. It checks the command while
// the command is held, and it checks the steered completion strobe.

module tb_cache_arbiter;

   typedef struct packed {
      logic         is_d;
      logic         rd;
      logic         wr;
      logic [15:0]  addr;
      logic [127:0] wdata;
   } txn_t;

   typedef struct packed {
      logic         rd;
      logic         wr;
      logic [15:0]  addr;
      logic [127:0] wdata;
   } djob_t;

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic         i_pmem_read = 1'b0;
   logic [15:0]  i_pmem_address = '0;
   logic         i_pmem_resp;
   logic [127:0] i_pmem_rdata;
   logic         d_pmem_read = 1'b0;
   logic         d_pmem_write = 1'b0;
   logic [15:0]  d_pmem_address = '0;
   logic [127:0] d_pmem_wdata = '0;
   logic         d_pmem_resp;
   logic [127:0] d_pmem_rdata;
   logic         pmem_read;
   logic         pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata;
   logic [127:0] pmem_rdata = '0;
   logic         pmem_resp = 1'b0;

   txn_t         sb[$];
   logic [15:0]  i_jobs[$];
   djob_t        d_jobs[$];
   int           passed_checks = 0;
   int           total_checks = 0;
   int           mem_lat = 2;
   int           glitch_cycles = 0;
   bit           inflight = 0;
   bit           expect_idle = 0;

   localparam logic [127:0] W1 = 128'hDEADBEEF_00112233_44556677_8899AABB;
   localparam logic [127:0] W2 = 128'hCAFEF00D_12345678_9ABCDEF0_0F1E2D3C;
   localparam logic [127:0] W3 = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] W4 = 128'hA5A5A5A5_5A5A5A5A_FFFF0000_0000FFFF;
   localparam logic [127:0] W5 = 128'h11112222_33334444_55556666_77778888;

   cache_arbiter dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .i_pmem_read    (i_pmem_read),
      .i_pmem_address (i_pmem_address),
      .i_pmem_resp    (i_pmem_resp),
      .i_pmem_rdata   (i_pmem_rdata),
      .d_pmem_read    (d_pmem_read),
      .d_pmem_write   (d_pmem_write),
      .d_pmem_address (d_pmem_address),
      .d_pmem_wdata   (d_pmem_wdata),
      .d_pmem_resp    (d_pmem_resp),
      .d_pmem_rdata   (d_pmem_rdata),
      .pmem_read      (pmem_read),
      .pmem_write     (pmem_write),
      .pmem_address   (pmem_address),
      .pmem_wdata     (pmem_wdata),
      .pmem_rdata     (pmem_rdata),
      .pmem_resp      (pmem_resp)
   );

   // Free-running clock with a 10 ns period.
   initial begin
      forever #5 clk = ~clk;
   end

   // The memory returns a line pattern that depends on the line address.
   function automatic logic [127:0] mem_line(input logic [15:0] a);
      return {a, ~a, a, ~a, a, ~a, a, ~a};
   endfunction

   task automatic check_output(input string name, input logic [127:0] actual,
                               input logic [127:0] required);
      total_checks++;
      if (actual === required) passed_checks++;
      else $display("[TB] FAIL %s: actual=%h required=%h", name, actual, required);
   endtask

   task automatic expect_txn(input logic is_d, input logic rd, input logic wr,
                             input logic [15:0] addr, input logic [127:0] wdata);
      txn_t t;
      t.is_d  = is_d;
      t.rd    = rd;
      t.wr    = wr;
      t.addr  = addr;
      t.wdata = wdata;
      sb.push_back(t);
   endtask

   task automatic push_djob(input logic rd, input logic wr, input logic [15:0] addr,
                            input logic [127:0] wdata);
      djob_t j;
      j.rd    = rd;
      j.wr    = wr;
      j.addr  = addr;
      j.wdata = wdata;
      d_jobs.push_back(j);
   endtask

   // Memory model. It answers a command after mem_lat cycles with a
   // one-cycle pmem_resp. It can also inject stray pmem_resp pulses.
   task automatic responder_proc();
      int cnt;
      cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!reset_n) begin
            cnt       = 0;
            pmem_resp = 1'b0;
         end else if (glitch_cycles > 0) begin
            pmem_resp  = 1'b1;
            pmem_rdata = mem_line(16'hFFF0);
            glitch_cycles--;
         end else if (pmem_resp) begin
            pmem_resp = 1'b0;
            cnt       = 0;
         end else if (pmem_read || pmem_write) begin
            cnt++;
            if (cnt >= mem_lat) begin
               pmem_resp  = 1'b1;
               pmem_rdata = mem_line(pmem_address);
            end
         end else begin
            cnt = 0;
         end
      end
   endtask

   // Monitor. It compares each new memory command with the scoreboard and
   // checks that the command holds. It checks the completion steering and the
   // mandatory idle cycle. It also checks that nothing leaks during reset.
   task automatic monitor_proc();
      txn_t cur;
      logic cmd;
      cur = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            check_output("reset_cmd", {pmem_read, pmem_write}, 0);
            check_output("reset_addr", pmem_address, 0);
            check_output("reset_wdata", pmem_wdata, 0);
            check_output("reset_resp", {i_pmem_resp, d_pmem_resp}, 0);
            inflight    = 0;
            expect_idle = 0;
         end else begin
            cmd = pmem_read | pmem_write;
            if (expect_idle) check_output("idle_gap", cmd, 0);
            expect_idle = 0;
            if (cmd && !inflight) begin
               if (sb.size() == 0) begin
                  check_output("unexpected_cmd", 1, 0);
               end else begin
                  cur      = sb.pop_front();
                  inflight = 1;
                  check_output("cmd_read", pmem_read, cur.rd);
                  check_output("cmd_write", pmem_write, cur.wr);
                  check_output("cmd_addr", pmem_address, cur.addr);
                  if (cur.wr) check_output("cmd_wdata", pmem_wdata, cur.wdata);
               end
            end else if (cmd && inflight) begin
               check_output("hold_cmd", {pmem_read, pmem_write}, {cur.rd, cur.wr});
               check_output("hold_addr", pmem_address, cur.addr);
               if (cur.wr) check_output("hold_wdata", pmem_wdata, cur.wdata);
            end else if (!cmd && inflight) begin
               check_output("cmd_lost", 0, 1);
               inflight = 0;
            end
            if (inflight && pmem_resp) begin
               check_output("resp_steer", {i_pmem_resp, d_pmem_resp}, {~cur.is_d, cur.is_d});
               check_output("i_rdata", i_pmem_rdata, mem_line(cur.addr));
               check_output("d_rdata", d_pmem_rdata, mem_line(cur.addr));
               inflight    = 0;
               expect_idle = 1;
            end else begin
               check_output("spurious_resp", {i_pmem_resp, d_pmem_resp}, 0);
            end
         end
      end
   endtask

   task automatic clear_traffic();
      i_pmem_read  = 1'b0;
      d_pmem_read  = 1'b0;
      d_pmem_write = 1'b0;
      i_jobs.delete();
      d_jobs.delete();
      sb.delete();
   endtask

   // Cache-controller behaviour. Each cache holds its request until it sees
   // its own resp, and then it presents its next queued job.
   task automatic apply_stimulus(input int budget);
      djob_t dj;
      bit    done;
      int    cyc;
      done = 0;
      cyc  = 0;
      while (!done && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (i_pmem_resp) i_pmem_read = 1'b0;
         if (d_pmem_resp) begin
            d_pmem_read  = 1'b0;
            d_pmem_write = 1'b0;
         end
         if (!i_pmem_read && i_jobs.size() > 0) begin
            i_pmem_address = i_jobs.pop_front();
            i_pmem_read    = 1'b1;
         end
         if (!d_pmem_read && !d_pmem_write && d_jobs.size() > 0) begin
            dj             = d_jobs.pop_front();
            d_pmem_read    = dj.rd;
            d_pmem_write   = dj.wr;
            d_pmem_address = dj.addr;
            d_pmem_wdata   = dj.wdata;
         end
         done = !i_pmem_read && !d_pmem_read && !d_pmem_write && i_jobs.size() == 0 &&
                d_jobs.size() == 0 && sb.size() == 0 && !inflight && !expect_idle;
      end
      if (!done) begin
         check_output("traffic_timeout", 0, 1);
         clear_traffic();
      end
   endtask

   task automatic wait_cmd(input string name, input int budget);
      int cyc;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(pmem_read || pmem_write) && cyc < budget);
      check_output(name, pmem_read | pmem_write, 1);
   endtask

   task automatic wait_drain(input int budget);
      int cyc;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while ((sb.size() != 0 || inflight || expect_idle) && cyc < budget);
      if (sb.size() != 0 || inflight) begin
         check_output("drain_timeout", 0, 1);
         clear_traffic();
      end
   endtask

   initial begin
      fork
         monitor_proc();
         responder_proc();
      join_none

      // Reset is held while both caches request. Nothing may leak out.
      // After release the D port gets the first contended grant, and the
      // grants then alternate.
      #1 reset_n = 1'b0;
      repeat (2) @(negedge clk);
      i_pmem_read    = 1'b1;
      i_pmem_address = 16'h0A5C;
      d_pmem_write   = 1'b1;
      d_pmem_address = 16'h3337;
      d_pmem_wdata   = W1;
      expect_txn(1'b1, 1'b0, 1'b1, 16'h3330, W1);
      expect_txn(1'b0, 1'b1, 1'b0, 16'h0A50, '0);
      expect_txn(1'b1, 1'b1, 1'b0, 16'h4440, '0);
      expect_txn(1'b0, 1'b1, 1'b0, 16'h0100, '0);
      expect_txn(1'b1, 1'b0, 1'b1, 16'h8000, W2);
      expect_txn(1'b0, 1'b1, 1'b0, 16'h0FF0, '0);
      push_djob(1'b1, 1'b0, 16'h4444, '0);
      push_djob(1'b0, 1'b1, 16'h8008, W2);
      i_jobs.push_back(16'h0100);
      i_jobs.push_back(16'h0FFF);
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);
      check_output("grant_latency", {pmem_read, pmem_write}, 2'b01);
      apply_stimulus(300);

      // A single I-cache fill with a slow memory.
      mem_lat = 5;
      i_jobs.push_back(16'h1236);
      expect_txn(1'b0, 1'b1, 1'b0, 16'h1230, '0);
      apply_stimulus(100);

      // D-cache traffic: a writeback, a fill, and a request with both
      // commands high, where the write must win. The last one runs with a
      // single-cycle memory.
      mem_lat = 3;
      push_djob(1'b0, 1'b1, 16'hBEEF, W3);
      push_djob(1'b1, 1'b0, 16'h4567, '0);
      expect_txn(1'b1, 1'b0, 1'b1, 16'hBEE0, W3);
      expect_txn(1'b1, 1'b1, 1'b0, 16'h4560, '0);
      apply_stimulus(100);
      mem_lat = 1;
      push_djob(1'b1, 1'b1, 16'h7001, W5);
      expect_txn(1'b1, 1'b0, 1'b1, 16'h7000, W5);
      apply_stimulus(100);

      // The D request is dropped and its inputs change in mid-service. The
      // registered command must hold, and d_pmem_resp must still pulse.
      mem_lat = 4;
      @(negedge clk);
      d_pmem_write   = 1'b1;
      d_pmem_address = 16'h2222;
      d_pmem_wdata   = W4;
      expect_txn(1'b1, 1'b0, 1'b1, 16'h2220, W4);
      wait_cmd("abandon_grant", 10);
      @(negedge clk);
      d_pmem_write   = 1'b0;
      d_pmem_address = 16'h9999;
      d_pmem_wdata   = ~W4;
      wait_drain(50);

      // Stray pmem_resp pulses while IDLE must not produce a cache resp.
      glitch_cycles = 2;
      repeat (4) @(negedge clk);
      check_output("idle_no_cmd", {pmem_read, pmem_write}, 0);

      // Reset arrives while an I fill is waiting on memory. The command must
      // drop at once with no resp, and a fresh request must be served.
      mem_lat = 20;
      @(negedge clk);
      i_pmem_read    = 1'b1;
      i_pmem_address = 16'h5678;
      expect_txn(1'b0, 1'b1, 1'b0, 16'h5670, '0);
      wait_cmd("abort_grant", 10);
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check_output("async_drop", pmem_read, 0);
      check_output("abort_no_resp", i_pmem_resp, 0);
      i_pmem_read = 1'b0;
      @(negedge clk);
      #2 reset_n = 1'b1;
      mem_lat = 2;
      i_jobs.push_back(16'h5678);
      expect_txn(1'b0, 1'b1, 1'b0, 16'h5670, '0);
      apply_stimulus(100);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule
